// File: rtl/project_fmr.sv
// Five-modular-redundancy voter stage: five replica channels with per-replica fault
// injection, a bitwise majority-of-five voter, and registered result/disagreement flags.

module fmr_replica (
    input  logic [4:0] x,
    input  logic       inject,
    output logic [4:0] r
);
    // A faulted replica inverts every bit of its operand.
    assign r = x ^ {5{inject}};
endmodule

module fmr_voter (
    input  logic [4:0][4:0] r,
    output logic [4:0]      v,
    output logic [4:0]      fault
);
    logic [2:0] sum;

    always_comb begin
        v     = '0;
        fault = '0;
        sum   = '0;
        for (int b = 0; b < 5; b++) begin
            sum = {2'b00, r[0][b]} + {2'b00, r[1][b]} + {2'b00, r[2][b]}
                + {2'b00, r[3][b]} + {2'b00, r[4][b]};
            v[b] = (sum >= 3'd3);
        end
        for (int i = 0; i < 5; i++) begin
            fault[i] = |(r[i] ^ v);
        end
    end
endmodule

module project_fmr (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] X,
    input  logic [4:0] g,
    output logic [4:0] a,
    output logic [4:0] fault
);
    logic [4:0][4:0] r;
    logic [4:0]      v;
    logic [4:0]      fault_d;
    logic [4:0]      a_q;
    logic [4:0]      fault_q;

    for (genvar i = 0; i < 5; i++) begin : g_replica
        fmr_replica u_replica (
            .x      (X),
            .inject (g[i]),
            .r      (r[i])
        );
    end

    fmr_voter u_voter (
        .r     (r),
        .v     (v),
        .fault (fault_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            fault_q <= '0;
        end else begin
            a_q     <= v;
            fault_q <= fault_d;
        end
    end

    assign a     = a_q;
    assign fault = fault_q;
endmodule

// File: tb/tb_project_fmr.sv
// Self-checking bench for project_fmr: directed test-plan steps, an X=g sweep with a
// mid-sweep reset, and randomized samples checked against a popcount-rule model.

module tb_project_fmr;
    logic       clk;
    logic       rst;
    logic [4:0] X;
    logic [4:0] g;
    logic [4:0] a;
    logic [4:0] fault;

    int checks;
    int failures;

    project_fmr dut (
        .clk   (clk),
        .rst   (rst),
        .X     (X),
        .g     (g),
        .a     (a),
        .fault (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Majority rule: up to two faults are masked, three or more flip the vote; the
    // flagged replicas are exactly those whose mask bit disagrees with the majority.
    function automatic logic [9:0] model(input logic [4:0] x, input logic [4:0] m);
        logic [4:0] va;
        logic [4:0] vf;
        if ($countones(m) <= 2) begin
            va = x;
            vf = m;
        end else begin
            va = ~x;
            vf = ~m;
        end
        return {va, vf};
    endfunction

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic r, input logic [4:0] x, input logic [4:0] m);
        @(negedge clk);
        rst = r;
        X   = x;
        g   = m;
        @(posedge clk);
        #1;
    endtask

    task automatic step_exp(input string tag, input logic r, input logic [4:0] x,
                            input logic [4:0] m, input logic [4:0] ea, input logic [4:0] ef);
        apply(r, x, m);
        check({tag, "_a"}, a, ea);
        check({tag, "_fault"}, fault, ef);
    endtask

    task automatic step_model(input string tag, input logic r, input logic [4:0] x,
                              input logic [4:0] m);
        logic [9:0] e;
        e = r ? 10'd0 : model(x, m);
        apply(r, x, m);
        check({tag, "_a"}, a, e[9:5]);
        check({tag, "_fault"}, fault, e[4:0]);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        X        = '0;
        g        = '0;

        step_exp("rst0", 1'b1, 5'd21, 5'd3, 5'd0, 5'd0);
        step_exp("rst1", 1'b1, 5'd21, 5'd3, 5'd0, 5'd0);
        step_exp("rel", 1'b0, 5'd21, 5'd3, 5'd21, 5'd3);

        step_exp("nf0", 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        step_exp("nf19", 1'b0, 5'd19, 5'd0, 5'd19, 5'd0);
        step_exp("c1", 1'b0, 5'd1, 5'd1, 5'd1, 5'd1);
        step_exp("c5", 1'b0, 5'd5, 5'd5, 5'd5, 5'd5);
        step_exp("c12", 1'b0, 5'd12, 5'd12, 5'd12, 5'd12);
        step_exp("u7", 1'b0, 5'd7, 5'd7, 5'd24, 5'd24);
        step_exp("u15", 1'b0, 5'd15, 5'd15, 5'd16, 5'd16);
        step_exp("u30", 1'b0, 5'd30, 5'd30, 5'd1, 5'd1);
        step_exp("all31", 1'b0, 5'd31, 5'd31, 5'd0, 5'd0);

        for (int v = 0; v < 32; v++) begin
            if (v == 16) begin
                step_exp("sweep_rst", 1'b1, v[4:0], v[4:0], 5'd0, 5'd0);
            end
            step_model("sweep", 1'b0, v[4:0], v[4:0]);
        end

        for (int n = 0; n < 300; n++) begin
            logic [4:0] rx;
            logic [4:0] rm;
            logic       rr;
            rx = 5'($urandom_range(0, 31));
            rm = 5'($urandom_range(0, 31));
            rr = ($urandom_range(0, 15) == 0);
            step_model("rand", rr, rx, rm);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
